// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the multi-cycle hazard unit
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_t;

  localparam int REG_X0 = 0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - single-operand forward selector, M stage beats W stage
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic                  reg_write_m_i,
  input  logic [REG_ADDR_W-1:0] rd_w_i,
  input  logic                  reg_write_w_i,
  output fwd_sel_t              sel_o
);

  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

  always_comb begin
    sel_o = FWD_RF;
    if (reg_write_m_i && rd_m_i != X0 && rd_m_i == rs_i) begin
      sel_o = FWD_MEM;
    end else if (reg_write_w_i && rd_w_i != X0 && rd_w_i == rs_i) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - 5-stage RV32 hazard/forwarding controller with
// memory-wait and MDU freezes, stall counter and stuck-stall watchdog
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  parameter int WD_W       = 8,
  parameter int WD_LIMIT   = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic                  mem_read_e,
  input  logic                  pc_src_e,
  input  logic                  mem_req_m,
  input  logic                  mem_ready_m,
  input  logic                  mdu_start_e,
  input  logic                  mdu_done,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  hazard_timeout
);

  localparam logic [REG_ADDR_W-1:0] X0     = REG_ADDR_W'(REG_X0);
  localparam logic [WD_W-1:0]       WD_LIM = WD_W'(WD_LIMIT);

  fwd_sel_t  fwd_a, fwd_b;
  hz_state_t state_q, state_d;
  logic      mdu_done_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [WD_W-1:0]  wd_q;
  logic      timeout_q;
  logic      mem_busy, lu, done_eff;
  logic      sf, sd, se, sm, fd, fe, fm;

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_i(rs1_e), .rd_m_i(rd_m), .reg_write_m_i(reg_write_m),
    .rd_w_i(rd_w), .reg_write_w_i(reg_write_w), .sel_o(fwd_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_i(rs2_e), .rd_m_i(rd_m), .reg_write_m_i(reg_write_m),
    .rd_w_i(rd_w), .reg_write_w_i(reg_write_w), .sel_o(fwd_b)
  );

  assign mem_busy = mem_req_m && !mem_ready_m;
  assign lu       = mem_read_e && rd_e != X0 && (rd_e == rs1_d || rd_e == rs2_d);
  assign done_eff = mdu_done || mdu_done_q;

  // Priority: memory freeze, then MDU wait, then branch, then load-use.
  // The first unfrozen cycle after MEM_WAIT is evaluated exactly like RUN.
  always_comb begin
    state_d = state_q;
    sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0;
    fd = 1'b0; fe = 1'b0; fm = 1'b0;
    if (mem_busy) begin
      sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1;
      if (state_q == RUN) state_d = MEM_WAIT;
    end else if ((state_q == MDU_WAIT || mdu_start_e) && !done_eff) begin
      sf = 1'b1; sd = 1'b1; se = 1'b1; fm = 1'b1;
      state_d = MDU_WAIT;
    end else begin
      state_d = RUN;
      if (state_q != MDU_WAIT) begin
        if (pc_src_e) begin
          fd = 1'b1; fe = 1'b1;
        end else if (lu) begin
          sf = 1'b1; sd = 1'b1; fe = 1'b1;
        end
      end
    end
  end

  assign forward_a_e    = rst_n ? fwd_a : FWD_RF;
  assign forward_b_e    = rst_n ? fwd_b : FWD_RF;
  assign stall_f        = rst_n && sf;
  assign stall_d        = rst_n && sd;
  assign stall_e        = rst_n && se;
  assign stall_m        = rst_n && sm;
  assign flush_d        = rst_n && fd;
  assign flush_e        = rst_n && fe;
  assign flush_m        = rst_n && fm;
  assign stall_cycles   = stall_cnt_q;
  assign hazard_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mdu_done_q  <= 1'b0;
      stall_cnt_q <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      // a completion seen while frozen is held until the next unfrozen cycle consumes it
      mdu_done_q <= mem_busy && done_eff;
      if (sf && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (state_q == RUN) begin
        wd_q <= '0;
      end else if (wd_q != WD_LIM) begin
        wd_q <= wd_q + 1'b1;
        if (wd_q + 1'b1 == WD_LIM) timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w, mem_read_e, pc_src_e;
  logic       mem_req_m, mem_ready_m, mdu_start_e, mdu_done;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m;
  logic [31:0] stall_cycles;
  logic       hazard_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_ADDR_W(5), .CNT_W(32), .WD_W(8), .WD_LIMIT(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_read_e(mem_read_e), .pc_src_e(pc_src_e),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .mdu_start_e(mdu_start_e), .mdu_done(mdu_done),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .stall_cycles(stall_cycles), .hazard_timeout(hazard_timeout)
  );

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m}
  wire [6:0] ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m};

  function automatic logic [1:0] ref_fwd(input int rs, input int rdm, input bit wm,
                                         input int rdw, input bit ww);
    if (wm && rdm != 0 && rdm == rs) return 2'b01;
    if (ww && rdw != 0 && rdw == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Pipeline running normally: a taken branch squashes D and E, otherwise a
  // load feeding decode stalls F/D one cycle and bubbles E.
  function automatic logic [6:0] ref_run(input bit lu, input bit br);
    if (br) return 7'b0000110;
    if (lu) return 7'b1100010;
    return 7'b0000000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0; mem_read_e = 0; pc_src_e = 0;
    mem_req_m = 0; mem_ready_m = 0; mdu_start_e = 0; mdu_done = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    reg_write_m = 1; rd_m = 5; rs1_e = 5; rs2_e = 5;
    mem_req_m = 1; mem_ready_m = 0;
    #1;
    checks++;
    if (ctl !== 7'b0 || forward_a_e !== 2'b00 || forward_b_e !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs got ctl=%b fa=%b fb=%b exp 0", ctl, forward_a_e, forward_b_e);
    end
    tick();
    tick();
    checks++;
    if (stall_cycles !== 32'd0 || hazard_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got cnt=%0d to=%b exp 0/0", stall_cycles, hazard_timeout);
    end
    idle();
    rst_n = 1;
    tick();
  endtask

  task automatic test_forwarding();
    logic [1:0] ea, eb;
    reg_write_m = 1; rd_m = 5; rs1_e = 5; reg_write_w = 1; rd_w = 5;
    #1;
    checks++;
    if (forward_a_e !== 2'b01) begin
      errors++;
      $display("FAIL fwd_m_priority got %b exp 01", forward_a_e);
    end
    rd_m = 0; rs1_e = 0;
    #1;
    checks++;
    if (forward_a_e !== 2'b00) begin
      errors++;
      $display("FAIL fwd_x0 got %b exp 00", forward_a_e);
    end
    for (int i = 0; i < 60; i++) begin
      rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
      rd_m  = 5'($urandom_range(0, 7)); rd_w  = 5'($urandom_range(0, 7));
      reg_write_m = 1'($urandom_range(0, 1)); reg_write_w = 1'($urandom_range(0, 1));
      ea = ref_fwd(int'(rs1_e), int'(rd_m), reg_write_m, int'(rd_w), reg_write_w);
      eb = ref_fwd(int'(rs2_e), int'(rd_m), reg_write_m, int'(rd_w), reg_write_w);
      #1;
      checks++;
      if (forward_a_e !== ea || forward_b_e !== eb) begin
        errors++;
        $display("FAIL fwd_rand[%0d] got a=%b b=%b exp a=%b b=%b", i, forward_a_e, forward_b_e, ea, eb);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    base = stall_cycles;
    mem_read_e = 1; rd_e = 7; rs2_d = 7; rs1_d = 3;
    #1;
    checks++;
    if (ctl !== 7'b1100010) begin
      errors++;
      $display("FAIL load_use got %b exp 1100010", ctl);
    end
    tick();
    checks++;
    if (stall_cycles !== base + 1) begin
      errors++;
      $display("FAIL load_use_cnt got %0d exp %0d", stall_cycles, base + 1);
    end
    rd_e = 0; rs1_d = 0; rs2_d = 0;
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL load_use_x0 got %b exp 0000000", ctl);
    end
    rd_e = 9; rs1_d = 9; pc_src_e = 1;
    #1;
    checks++;
    if (ctl !== 7'b0000110) begin
      errors++;
      $display("FAIL branch_beats_lu got %b exp 0000110", ctl);
    end
    idle();
    tick();
  endtask

  task automatic test_random_run();
    logic [31:0] base;
    logic [6:0]  exp;
    bit          lu;
    int          nstall = 0;
    base = stall_cycles;
    for (int i = 0; i < 60; i++) begin
      mem_read_e = 1'($urandom_range(0, 1));
      rd_e  = 5'($urandom_range(0, 3));
      rs1_d = 5'($urandom_range(0, 3));
      rs2_d = 5'($urandom_range(0, 3));
      pc_src_e = ($urandom_range(0, 3) == 0);
      lu = mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      exp = ref_run(lu, pc_src_e);
      if (exp[6]) nstall++;
      #1;
      checks++;
      if (ctl !== exp) begin
        errors++;
        $display("FAIL run_rand[%0d] got %b exp %b", i, ctl, exp);
      end
      tick();
    end
    checks++;
    if (stall_cycles !== base + 32'(nstall)) begin
      errors++;
      $display("FAIL run_rand_cnt got %0d exp %0d", stall_cycles, base + 32'(nstall));
    end
    idle();
    tick();
  endtask

  task automatic test_mem_freeze();
    logic [31:0] base;
    base = stall_cycles;
    mem_req_m = 1; mem_ready_m = 0; pc_src_e = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 7'b1111000) begin
        errors++;
        $display("FAIL mem_freeze[%0d] got %b exp 1111000", i, ctl);
      end
      tick();
    end
    mem_ready_m = 1;
    #1;
    checks++;
    if (ctl !== 7'b0000110) begin
      errors++;
      $display("FAIL mem_release_branch got %b exp 0000110", ctl);
    end
    tick();
    idle();
    #1;
    checks++;
    if (stall_cycles !== base + 3 || ctl !== 7'b0) begin
      errors++;
      $display("FAIL mem_freeze_cnt got cnt=%0d ctl=%b exp cnt=%0d ctl=0", stall_cycles, ctl, base + 3);
    end
    tick();
  endtask

  task automatic test_mdu();
    logic [31:0] base;
    base = stall_cycles;
    mdu_start_e = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== 7'b1110001) begin
        errors++;
        $display("FAIL mdu_wait[%0d] got %b exp 1110001", i, ctl);
      end
      tick();
    end
    mdu_done = 1;
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL mdu_done got %b exp 0000000", ctl);
    end
    tick();
    idle();
    #1;
    checks++;
    if (stall_cycles !== base + 4) begin
      errors++;
      $display("FAIL mdu_cnt got %0d exp %0d", stall_cycles, base + 4);
    end
    mdu_start_e = 1; mdu_done = 1;
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL mdu_zero_latency got %b exp 0000000", ctl);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_mdu_mem_overlap();
    mdu_start_e = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== 7'b1110001) begin
        errors++;
        $display("FAIL ovl_mdu[%0d] got %b exp 1110001", i, ctl);
      end
      tick();
    end
    mem_req_m = 1; mem_ready_m = 0; mdu_done = 1;
    #1;
    checks++;
    if (ctl !== 7'b1111000) begin
      errors++;
      $display("FAIL ovl_freeze_done got %b exp 1111000", ctl);
    end
    tick();
    mdu_done = 0;
    #1;
    checks++;
    if (ctl !== 7'b1111000) begin
      errors++;
      $display("FAIL ovl_freeze got %b exp 1111000", ctl);
    end
    tick();
    mem_ready_m = 1;
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL ovl_release got %b exp 0000000", ctl);
    end
    tick();
    idle();
    mem_read_e = 1; rd_e = 4; rs1_d = 4;
    #1;
    checks++;
    if (ctl !== 7'b1100010) begin
      errors++;
      $display("FAIL ovl_back_in_run got %b exp 1100010", ctl);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_watchdog();
    mem_req_m = 1; mem_ready_m = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 8) begin
        checks++;
        if (hazard_timeout !== 1'b0) begin
          errors++;
          $display("FAIL wd_early got %b exp 0", hazard_timeout);
        end
      end
    end
    checks++;
    if (hazard_timeout !== 1'b1) begin
      errors++;
      $display("FAIL wd_raise got %b exp 1", hazard_timeout);
    end
    mem_ready_m = 1;
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (hazard_timeout !== 1'b1 || ctl !== 7'b0) begin
      errors++;
      $display("FAIL wd_sticky got to=%b ctl=%b exp to=1 ctl=0", hazard_timeout, ctl);
    end
    mem_req_m = 1; mem_ready_m = 0;
    tick();
    tick();
    rst_n = 0;
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_freeze got %b exp 0000000", ctl);
    end
    tick();
    rst_n = 1;
    idle();
    #1;
    checks++;
    if (ctl !== 7'b0 || hazard_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL after_reset got ctl=%b to=%b cnt=%0d exp 0/0/0", ctl, hazard_timeout, stall_cycles);
    end
    mem_read_e = 1; rd_e = 6; rs2_d = 6;
    #1;
    checks++;
    if (ctl !== 7'b1100010) begin
      errors++;
      $display("FAIL after_reset_run got %b exp 1100010", ctl);
    end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_random_run();
    test_mem_freeze();
    test_mdu();
    test_mdu_mem_overlap();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor hazard/forwarding controller for the 5-stage RV32 pipeline; sits beside the datapath and drives the stage-register enables, flushes and ALU operand mux selects.
- Adds the following over the single-cycle version:
  - x0- and write-enable-qualified forwarding.
  - Decode-vs-execute load-use detection.
  - Branch/jump flush arbitration.
  - Multi-cycle freezes for data-memory wait and an iterative mul/div unit (MDU), tracked by a state machine.
  - Stall-cycle performance counter and a stuck-stall watchdog.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, stall-cycle counter width.
- WD_W, 8, watchdog counter width.
- WD_LIMIT, 200, consecutive non-RUN cycles before hazard_timeout is raised; must be < 2**WD_W.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- rs1_d, rs2_d  in  REG_ADDR_W  source registers in decode.
- rs1_e, rs2_e, rd_e  in  REG_ADDR_W  source/dest registers in execute.
- rd_m, rd_w  in  REG_ADDR_W  dest registers in memory/writeback.
- reg_write_m, reg_write_w  in  1  register write enables in M/W.
- mem_read_e  in  1  execute instruction is a load.
- pc_src_e  in  1  taken branch/jump resolved in execute.
- mem_req_m, mem_ready_m  in  1  data-memory access in M / access completes this cycle.
- mdu_start_e, mdu_done  in  1  MDU op in E (level) / result valid (1-cycle pulse).
- forward_a_e, forward_b_e  out  2  operand select: 00 regfile, 01 from M, 10 from W.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the stage register.
- flush_d, flush_e, flush_m  out  1  insert a bubble into the stage register.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_f high.
- hazard_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to RUN.
  - stall_cycles, watchdog count, mdu_done_q and hazard_timeout are cleared to 0.
  - While rst_n is low, every stall, flush and forward output is forced to 0.
- Forwarding (combinational, every state including freezes):
  - forward_a_e = 01 if reg_write_m && rd_m != 0 && rd_m == rs1_e.
  - Else 10 if reg_write_w && rd_w != 0 && rd_w == rs1_e.
  - Else 00. M has priority over W. forward_b_e is identical using rs2_e.
- Load-use (RUN only):
  - Condition: lu = mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d).
  - When lu: stall_f = stall_d = 1 and flush_e = 1 for exactly that cycle (one bubble).
- Branch (RUN only):
  - When pc_src_e: flush_d = flush_e = 1.
  - Branch beats load-use in the same cycle: no stall, both flushes asserted.
- Freeze conditions:
  - mem_busy = mem_req_m && !mem_ready_m.
  - While mem_busy (any state): stall_f/d/e/m = 1 and all flushes = 0. A pending pc_src_e is held in E and acts on the first unfrozen cycle.
- State machine, RUN / MEM_WAIT / MDU_WAIT:
  - RUN → MEM_WAIT on mem_busy. MEM_WAIT → RUN when mem_ready_m, unless an MDU op is outstanding in E, in which case → MDU_WAIT.
  - RUN → MDU_WAIT on mdu_start_e && !mdu_done && !mem_busy. A same-cycle mdu_done (zero-latency op) causes no stall.
  - In MDU_WAIT: stall_f/d/e = 1 and flush_m = 1 every cycle, until the cycle mdu_done (or mdu_done_q) is seen; that cycle outputs no stall and the FSM returns to RUN.
  - mdu_done arriving during MEM_WAIT is latched in mdu_done_q, which is cleared when consumed.
- Priority when conditions coincide: mem_busy > MDU wait > branch > load-use.
- stall_cycles: +1 on each cycle with stall_f high; saturates at all ones and does not wrap.
- Watchdog:
  - Counts consecutive cycles not in RUN and clears to 0 in RUN.
  - Reaching WD_LIMIT sets hazard_timeout, which stays high until reset.
  - The watchdog does not alter stall behaviour.
- Reset asserted mid-freeze: the freeze ends the next cycle with no residual stall or flush.

Decomposition:
- hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10.
  - hz_state_t enum: RUN, MEM_WAIT, MDU_WAIT.
  - REG_X0 constant.
- Sub-module hazard_fwd_sel: combinational single-operand forward selector, instantiated twice (operands A and B).

Test Plan:
- add x5 in M (reg_write_m = 1), rs1_e = 5, rd_w = 5 with reg_write_w = 1 → forward_a_e = 01; same with rd_m = 0 and rs1_e = 0 → 00.
- lw x7 in E, rs2_d = 7 → one cycle of stall_f = stall_d = flush_e = 1, stall_cycles = 1; rd_e = 0 → no stall.
- lu and pc_src_e in the same cycle → flush_d = flush_e = 1, stall_f = 0.
- mem_req_m high, mem_ready_m low for 3 cycles, pc_src_e held high → stall_f/d/e/m high for 3 cycles with flushes 0, then flush_d = flush_e on the release cycle; stall_cycles = 3.
- mdu_start_e, mdu_done pulsing 4 cycles later → 4 cycles of stall_f/d/e with flush_m high, then RUN. A second run with mem_busy overlapping mdu_done → done latched, no deadlock.
- WD_LIMIT = 10, mem_ready_m held low 12 cycles → hazard_timeout rises on the 10th cycle and persists; pulling rst_n low for one cycle clears everything.
